// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one byte-wide main-memory port between the instruction cache and
//   the data cache. Each grant moves one 4-byte line: icache fills, dcache
//   fills and dcache write-backs. Bytes go out one per cycle; a fill returns
//   the assembled line together with a one-cycle done pulse.
//
// Ports
//   clk, rst          clock; synchronous active-low reset (0 = reset)
//   i_req, i_addr     icache line-read request (held until i_done)
//   i_rdata, i_done   icache line result and completion pulse
//   d_req, d_we       dcache line request; d_we = 1 for write-back
//   d_addr, d_wdata   dcache line address and write-back line
//   d_rdata, d_done   dcache line result and completion pulse
//   mem_a, mem_dout   memory byte address and write byte
//   mem_wr            write strobe for mem_dout at mem_a
//   mem_din           read byte, one cycle after mem_a
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t            state;
  logic [2:0]        cnt;
  logic              owner;
  logic              last_grant;
  logic              we;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata;
  logic [23:0]       line_lo;

  logic              grant_any;
  logic              grant_d;
  logic              grant_we;
  logic [ADDR_W-1:0] grant_base;

  // Round-robin: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_any  = i_req | d_req;
    grant_d    = d_req & (~i_req | (last_grant == OWN_I));
    grant_we   = grant_d & d_we;
    grant_base = (grant_d ? d_addr : i_addr) & ~ADDR_W'(3);
  end

  // Lines are 4-byte aligned, so the byte offset never carries out of [1:0].
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] b,
                                                   input logic [1:0]        k);
    return b | ADDR_W'(k);
  endfunction

  function automatic logic [7:0] line_byte(input logic [31:0] w,
                                           input logic [1:0]  k);
    return w[8*k +: 8];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= OWN_I;
      last_grant <= OWN_I;
      we         <= 1'b0;
      base       <= '0;
      wdata      <= '0;
      line_lo    <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      case (state)
        IDLE: begin
          mem_a    <= '0;
          mem_wr   <= 1'b0;
          mem_dout <= '0;
          if (grant_any) begin
            owner      <= grant_d;
            last_grant <= grant_d;
            we         <= grant_we;
            base       <= grant_base;
            wdata      <= d_wdata;
            cnt        <= '0;
            line_lo    <= '0;
            // Outputs are registered, so byte 0 is presented on the first BUSY cycle.
            mem_a      <= grant_base;
            mem_wr     <= grant_we;
            mem_dout   <= grant_we ? d_wdata[7:0] : 8'h00;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (we) begin
            if (cnt == 3'd3) begin
              state    <= DONE;
              cnt      <= '0;
              mem_a    <= '0;
              mem_wr   <= 1'b0;
              mem_dout <= '0;
              i_done   <= (owner == OWN_I);
              d_done   <= (owner == OWN_D);
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= byte_addr(base, cnt[1:0] + 2'd1);
              mem_dout <= line_byte(wdata, cnt[1:0] + 2'd1);
            end
          end else begin
            // mem_din lags mem_a by one cycle, so byte k lands while cnt = k+1.
            cnt <= cnt + 3'd1;
            case (cnt)
              3'd1:    line_lo[7:0]   <= mem_din;
              3'd2:    line_lo[15:8]  <= mem_din;
              3'd3:    line_lo[23:16] <= mem_din;
              default: ;
            endcase
            if (cnt == 3'd4) begin
              state  <= DONE;
              cnt    <= '0;
              mem_a  <= '0;
              i_done <= (owner == OWN_I);
              d_done <= (owner == OWN_D);
              if (owner == OWN_I) i_rdata <= {mem_din, line_lo};
              else                d_rdata <= {mem_din, line_lo};
            end else if (cnt != 3'd3) begin
              // At cnt = 3 the address simply stays on byte 3 for the extra cycle.
              mem_a <= byte_addr(base, cnt[1:0] + 2'd1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
